// File: rtl/step_if_pkg.sv
// Shared encodings for the step-pulse tracker: FSM states, fault-code bit
// positions, axis indices and step-direction sign values.
package step_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int FC_CONFLICT = 0;
  localparam int FC_SEQ      = 1;
  localparam int FC_RANGE    = 2;

  localparam int NUM_AXES = 2;
  localparam int AXIS_X   = 0;
  localparam int AXIS_Y   = 1;

  // Value of an endpoint's sign bit for each travel direction.
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/step_pulse_tracker_if.sv
// Bundle between the interpolator side (master) and the tracker (slave):
// arm/endpoint, the four step pulses, and the tracked position/status.
interface step_pulse_tracker_if #(
  parameter int POS_W = 32,
  parameter int CNT_W = 32
);
  logic                    arm;
  logic signed [POS_W-1:0] Xe;
  logic signed [POS_W-1:0] Ye;
  logic                    r_Ax;
  logic                    r_fAx;
  logic                    r_Ay;
  logic                    r_fAy;
  logic signed [POS_W-1:0] pos_x;
  logic signed [POS_W-1:0] pos_y;
  logic [CNT_W-1:0]        step_cnt;
  logic                    busy;
  logic                    done;
  logic                    fault;
  logic [2:0]              fault_code;

  modport master (
    output arm, Xe, Ye, r_Ax, r_fAx, r_Ay, r_fAy,
    input  pos_x, pos_y, step_cnt, busy, done, fault, fault_code
  );

  modport slave (
    input  arm, Xe, Ye, r_Ax, r_fAx, r_Ay, r_fAy,
    output pos_x, pos_y, step_cnt, busy, done, fault, fault_code
  );
endinterface

// File: rtl/step_edge_capture.sv
// Registers one axis' +/- pulse pair twice and turns rising edges into
// single-cycle events, so a pulse held for many cycles counts once.
module step_edge_capture (
  input  logic clk,
  input  logic reset,
  input  logic pulse_pos,
  input  logic pulse_neg,
  output logic pos_evt,
  output logic neg_evt,
  output logic conflict
);
  logic [1:0] s_reg;
  logic [1:0] p_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg <= '0;
      p_reg <= '0;
    end else begin
      s_reg <= {pulse_neg, pulse_pos};
      p_reg <= s_reg;
    end
  end

  assign pos_evt  = s_reg[0] & ~p_reg[0];
  assign neg_evt  = s_reg[1] & ~p_reg[1];
  assign conflict = pos_evt & neg_evt;
endmodule

// File: rtl/step_pulse_tracker.sv
// Position tracker/monitor for the line interpolator's step pulses: rebuilds
// X/Y position, re-runs the comparison deviation and flags illegal steps.
module step_pulse_tracker
  import step_if_pkg::*;
#(
  parameter int POS_W     = 32,
  parameter int CNT_W     = 32,
  parameter int STALL_CYC = 4096
) (
  input logic                 clk,
  input logic                 reset,
  step_pulse_tracker_if.slave bus
);
  localparam int F_W     = POS_W + 2;
  localparam int STALL_W = $clog2(STALL_CYC + 1);

  logic [NUM_AXES-1:0] pulse_pos, pulse_neg, evt_pos, evt_neg, evt_conf;

  state_t                  state_reg;
  logic signed [POS_W-1:0] pos_reg [NUM_AXES];
  logic signed [POS_W-1:0] end_reg [NUM_AXES];
  logic [POS_W-1:0]        abs_reg [NUM_AXES];
  logic [NUM_AXES-1:0]     sgn_reg;
  logic signed [F_W-1:0]   f_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [2:0]              fc_reg;
  logic [STALL_W-1:0]      stall_reg;

  logic signed [POS_W-1:0] arm_end      [NUM_AXES];
  logic [POS_W-1:0]        arm_abs      [NUM_AXES];
  logic signed [POS_W-1:0] pos_next     [NUM_AXES];
  logic [POS_W-1:0]        pos_next_abs [NUM_AXES];
  logic signed [F_W-1:0]   abs_ext      [NUM_AXES];
  logic [NUM_AXES-1:0]     single, dir_bad, acc, over, hit;

  logic                  f_pos, f_neg, seq_bad, any_conf, any_dir, bad;
  logic                  stall_hit, range_bad, any_evt;
  logic signed [F_W-1:0] f_next;
  logic [CNT_W-1:0]      cnt_next;
  logic [2:0]            fc_bad;

  assign pulse_pos        = {bus.r_Ay, bus.r_Ax};
  assign pulse_neg        = {bus.r_fAy, bus.r_fAx};
  assign arm_end[AXIS_X] = bus.Xe;
  assign arm_end[AXIS_Y] = bus.Ye;

  generate
    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      step_edge_capture u_cap (
        .clk      (clk),
        .reset    (reset),
        .pulse_pos(pulse_pos[gi]),
        .pulse_neg(pulse_neg[gi]),
        .pos_evt  (evt_pos[gi]),
        .neg_evt  (evt_neg[gi]),
        .conflict (evt_conf[gi])
      );

      assign arm_abs[gi] = arm_end[gi][POS_W-1] ? -arm_end[gi] : arm_end[gi];
      assign single[gi]  = evt_pos[gi] ^ evt_neg[gi];
      // A step must head towards the endpoint; a zero-length axis never steps.
      assign dir_bad[gi] =
          (evt_pos[gi] & ~evt_neg[gi] & ((sgn_reg[gi] == DIR_NEG) || (abs_reg[gi] == '0))) |
          (evt_neg[gi] & ~evt_pos[gi] & (sgn_reg[gi] == DIR_POS));
      assign pos_next[gi] = !acc[gi]    ? pos_reg[gi] :
                            evt_pos[gi] ? pos_reg[gi] + POS_W'(1) :
                                          pos_reg[gi] - POS_W'(1);
      assign pos_next_abs[gi] = pos_next[gi][POS_W-1] ? -pos_next[gi] : pos_next[gi];
      assign over[gi]    = acc[gi] & (pos_next_abs[gi] > abs_reg[gi]);
      assign hit[gi]     = (pos_next[gi] == end_reg[gi]);
      assign abs_ext[gi] = {2'b00, abs_reg[gi]};
    end
  endgenerate

  assign f_pos    = ~f_reg[F_W-1] & (|f_reg);
  assign f_neg    = f_reg[F_W-1];
  assign seq_bad  = (single[AXIS_X] & f_pos) | (single[AXIS_Y] & f_neg);
  assign any_conf = |evt_conf;
  assign any_dir  = |dir_bad;
  assign bad      = any_conf | any_dir | seq_bad;
  assign acc      = single & {NUM_AXES{~bad}};
  assign any_evt  = |(evt_pos | evt_neg);

  assign f_next = f_reg + (acc[AXIS_X] ? abs_ext[AXIS_Y] : '0)
                        - (acc[AXIS_Y] ? abs_ext[AXIS_X] : '0);
  assign cnt_next  = cnt_reg + CNT_W'(acc[AXIS_X]) + CNT_W'(acc[AXIS_Y]);
  assign stall_hit = ~(|acc) & (stall_reg == STALL_W'(STALL_CYC - 1));
  assign range_bad = (|over) | stall_hit;

  always_comb begin
    fc_bad              = '0;
    fc_bad[FC_CONFLICT] = any_conf;
    fc_bad[FC_SEQ]      = any_dir | seq_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      for (int i = 0; i < NUM_AXES; i++) begin
        pos_reg[i] <= '0;
        end_reg[i] <= '0;
        abs_reg[i] <= '0;
      end
      sgn_reg   <= '0;
      f_reg     <= '0;
      cnt_reg   <= '0;
      fc_reg    <= '0;
      stall_reg <= '0;
    end else begin
      case (state_reg)
        TRACK: begin
          // Illegal steps freeze position; overshoot still records the step.
          if (bad) begin
            fc_reg    <= fc_reg | fc_bad;
            state_reg <= FAULT;
          end else begin
            for (int i = 0; i < NUM_AXES; i++) pos_reg[i] <= pos_next[i];
            f_reg     <= f_next;
            cnt_reg   <= cnt_next;
            stall_reg <= (|acc) ? '0 : stall_reg + STALL_W'(1);
            if (range_bad) begin
              fc_reg[FC_RANGE] <= 1'b1;
              state_reg        <= FAULT;
            end else if (&hit) begin
              state_reg <= DONE;
            end
          end
        end
        default: begin
          if (bus.arm) begin
            for (int i = 0; i < NUM_AXES; i++) begin
              end_reg[i] <= arm_end[i];
              abs_reg[i] <= arm_abs[i];
              sgn_reg[i] <= arm_end[i][POS_W-1];
              pos_reg[i] <= '0;
            end
            f_reg     <= '0;
            cnt_reg   <= '0;
            fc_reg    <= '0;
            stall_reg <= '0;
            state_reg <= (bus.Xe == '0 && bus.Ye == '0) ? DONE : TRACK;
          end else if (state_reg == DONE && any_evt) begin
            fc_reg[FC_RANGE] <= 1'b1;
            state_reg        <= FAULT;
          end
        end
      endcase
    end
  end

  assign bus.pos_x      = pos_reg[AXIS_X];
  assign bus.pos_y      = pos_reg[AXIS_Y];
  assign bus.step_cnt   = cnt_reg;
  assign bus.busy       = (state_reg == TRACK);
  assign bus.done       = (state_reg == DONE);
  assign bus.fault      = (state_reg == FAULT);
  assign bus.fault_code = fc_reg;
endmodule

// File: tb/tb_step_pulse_tracker.sv
// Directed table-driven bench for step_pulse_tracker plus hand-written
// sequences for stall, held pulses, idle behaviour and reset.
module tb_step_pulse_tracker;
  localparam int POS_W     = 32;
  localparam int CNT_W     = 32;
  localparam int STALL_CYC = 16;

  localparam logic [3:0] PX = 4'b1000;
  localparam logic [3:0] NX = 4'b0100;
  localparam logic [3:0] PY = 4'b0010;
  localparam logic [3:0] NY = 4'b0001;
  localparam logic [3:0] NP = 4'b0000;

  localparam logic [2:0] SB = 3'b100;  // busy
  localparam logic [2:0] SD = 3'b010;  // done
  localparam logic [2:0] SF = 3'b001;  // fault
  localparam logic [2:0] SI = 3'b000;  // idle

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  step_pulse_tracker_if #(.POS_W(POS_W), .CNT_W(CNT_W)) bus_if ();

  step_pulse_tracker #(
    .POS_W    (POS_W),
    .CNT_W    (CNT_W),
    .STALL_CYC(STALL_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct {
    logic       is_arm;
    int         xe;
    int         ye;
    logic [3:0] p;
    int         ex_x;
    int         ex_y;
    int         ex_cnt;
    logic [2:0] ex_bdf;
    logic [2:0] ex_fc;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic a, input int xe, input int ye, input logic [3:0] p,
                              input int x, input int y, input int c,
                              input logic [2:0] bdf, input logic [2:0] fc);
    vec_t v;
    v.is_arm = a;   v.xe = xe;   v.ye = ye;   v.p = p;
    v.ex_x   = x;   v.ex_y = y;  v.ex_cnt = c;
    v.ex_bdf = bdf; v.ex_fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] p);
    bus_if.r_Ax  = p[3];
    bus_if.r_fAx = p[2];
    bus_if.r_Ay  = p[1];
    bus_if.r_fAy = p[0];
  endtask

  task automatic do_arm(input int xe, input int ye);
    @(negedge clk);
    bus_if.arm = 1'b1;
    bus_if.Xe  = xe;
    bus_if.Ye  = ye;
    @(negedge clk);
    bus_if.arm = 1'b0;
  endtask

  // One-cycle pulse; returns once the resulting update edge has passed.
  task automatic do_pulse(input logic [3:0] p);
    @(negedge clk);
    drive(p);
    @(negedge clk);
    drive(NP);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input int idx, input int x, input int y,
                           input int c, input logic [2:0] bdf, input logic [2:0] fc);
    chk({tag, ".pos_x"}, idx, longint'(bus_if.pos_x), longint'(x));
    chk({tag, ".pos_y"}, idx, longint'(bus_if.pos_y), longint'(y));
    chk({tag, ".step_cnt"}, idx, longint'(bus_if.step_cnt), longint'(c));
    chk({tag, ".state"}, idx, longint'({bus_if.busy, bus_if.done, bus_if.fault}), longint'(bdf));
    chk({tag, ".fault_code"}, idx, longint'(bus_if.fault_code), longint'(fc));
    $display("%s %0d: pos=(%0d,%0d) cnt=%0d bdf=%b fc=%b", tag, idx,
             bus_if.pos_x, bus_if.pos_y, bus_if.step_cnt,
             {bus_if.busy, bus_if.done, bus_if.fault}, bus_if.fault_code);
  endtask

  initial begin
    reset      = 1'b1;
    bus_if.arm = 1'b0;
    bus_if.Xe  = '0;
    bus_if.Ye  = '0;
    drive(NP);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all("reset", 0, 0, 0, 0, SI, 3'b000);

    // Events in IDLE are ignored without a fault.
    do_pulse(PX);
    check_all("idle", 0, 0, 0, 0, SI, 3'b000);

    // Legal 5,3 line.
    tbl.push_back(mk(1,  5, 3, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 1, 0, 1, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, 1, 1, 2, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 2, 1, 3, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, 2, 2, 4, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 3, 2, 5, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 4, 2, 6, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, 4, 3, 7, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 5, 3, 8, SD, 3'b000));
    // -4,4 with a simultaneous first step at F==0.
    tbl.push_back(mk(1, -4, 4, NP,  0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, NX | PY, -1, 1, 2, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, NX, -2, 1, 3, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, -2, 2, 4, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, NX, -3, 2, 5, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, -3, 3, 6, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, NX, -4, 3, 7, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, -4, 4, 8, SD, 3'b000));
    // X conflict.
    tbl.push_back(mk(1,  3, 2, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX | NX, 0, 0, 0, SF, 3'b001));
    // X sequence violation (second +X at F=1).
    tbl.push_back(mk(1,  3, 1, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 1, 0, 1, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 1, 0, 1, SF, 3'b010));
    // Step after DONE is an overshoot.
    tbl.push_back(mk(1,  2, 0, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 1, 0, 1, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 2, 0, 2, SD, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 2, 0, 2, SF, 3'b100));
    // Wrong X direction.
    tbl.push_back(mk(1,  3, 2, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, NX, 0, 0, 0, SF, 3'b010));
    // Y conflict.
    tbl.push_back(mk(1,  3, 2, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY | NY, 0, 0, 0, SF, 3'b001));
    // Zero-length move goes straight to DONE.
    tbl.push_back(mk(1,  0, 0, NP, 0, 0, 0, SD, 3'b000));
    // Y sequence violation (second +Y at F=-1).
    tbl.push_back(mk(1,  1, 3, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, 0, 1, 1, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PY, 0, 1, 1, SF, 3'b010));
    // Joint X+Y with F != 0.
    tbl.push_back(mk(1,  2, 2, NP, 0, 0, 0, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX, 1, 0, 1, SB, 3'b000));
    tbl.push_back(mk(0,  0, 0, PX | PY, 1, 0, 1, SF, 3'b010));

    foreach (tbl[i]) begin
      if (tbl[i].is_arm) do_arm(tbl[i].xe, tbl[i].ye);
      else               do_pulse(tbl[i].p);
      check_all("vec", i, tbl[i].ex_x, tbl[i].ex_y, tbl[i].ex_cnt, tbl[i].ex_bdf, tbl[i].ex_fc);
    end

    // Stall: fault on exactly the STALL_CYC-th idle TRACK cycle.
    do_arm(1, 1);
    repeat (STALL_CYC - 1) @(negedge clk);
    check_all("stall_pre", 0, 0, 0, 0, SB, 3'b000);
    @(negedge clk);
    check_all("stall", 0, 0, 0, 0, SF, 3'b100);

    // A pulse held for 5 cycles is one step.
    do_arm(1, 1);
    check_all("rearm", 0, 0, 0, 0, SB, 3'b000);
    @(negedge clk);
    drive(PX);
    repeat (5) @(negedge clk);
    drive(NP);
    repeat (2) @(negedge clk);
    check_all("hold", 0, 1, 0, 1, SB, 3'b000);

    // Reset in the middle of TRACK.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all("midreset", 0, 0, 0, 0, SI, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_pulse_tracker.md
Name: step_pulse_tracker

Overview:
- Receiving end of the interpolator step-pulse interface: consumes the four axis pulses (+X, -X, +Y, -Y) that the line interpolator emits.
- Reconstructs signed X/Y position and counts accepted steps.
- Independently re-runs the point-by-point comparison deviation to check that every step was legal.
- Reports arrival at the programmed endpoint, or a fault; sits between interpolator and axis drivers as position tracker/monitor.

Parameters:
- POS_W, 32, width of signed endpoint and position values.
- CNT_W, 32, width of accepted-step counter.
- STALL_CYC, 4096, cycles with no accepted step in TRACK before a stall fault.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle start strobe; latches Xe/Ye.
- Xe  in  POS_W  signed X endpoint, relative to start.
- Ye  in  POS_W  signed Y endpoint, relative to start.
- r_Ax  in  1  +X step pulse.
- r_fAx  in  1  -X step pulse.
- r_Ay  in  1  +Y step pulse.
- r_fAy  in  1  -Y step pulse.
- pos_x  out  POS_W  signed tracked X position.
- pos_y  out  POS_W  signed tracked Y position.
- step_cnt  out  CNT_W  accepted steps, X and Y counted separately.
- busy  out  1  high in TRACK.
- done  out  1  high in DONE.
- fault  out  1  high in FAULT.
- fault_code  out  3  bit0 conflict, bit1 sequence/direction, bit2 overshoot/stall; sticky until next arm.

Behaviour:
- Reset: state IDLE; pos_x, pos_y, step_cnt, deviation F, fault_code, busy, done, fault all 0; pulse history registers 0.
- Pulse capture: each of the 4 inputs is registered (s) and delayed once more (p); an event is s & ~p.
  - A pulse held N cycles counts once.
  - Input first sampled high at edge k gives an event in the cycle after k; pos/step_cnt reflect it after edge k+1.
  - Capture runs in every state.
- arm in IDLE, DONE or FAULT:
  - Latch Xe, Ye, |Xe|, |Ye| and sign bits.
  - Clear pos, step_cnt, F, fault_code and stall counter.
  - Next state TRACK, or DONE directly if Xe==0 and Ye==0.
  - Events in the arm cycle itself are discarded.
- arm in TRACK: ignored.
- TRACK, per cycle, evaluated on pre-update values:
  - X conflict: +X and -X events in the same cycle. Sets bit0, FAULT, no update.
  - X direction: +X event requires Xe>0; -X requires Xe<0. Violation sets bit1, FAULT.
  - Sequence: an X event requires F<=0; a Y event requires F>=0. X and Y together are legal only when F==0. Violation sets bit1.
  - Y axis: same rules as X for conflict, direction and sequence.
  - Accepted X step: pos_x ±1; F += |Ye|; step_cnt += 1.
  - Accepted Y step: pos_y ±1; F -= |Xe|; step_cnt += 1.
  - Accepted X and Y in one cycle: both updates apply, F += |Ye| - |Xe|, step_cnt += 2.
  - F is signed, POS_W+2 bits.
  - Overshoot: an accepted step that makes |pos_x|>|Xe| or |pos_y|>|Ye| sets bit2, FAULT; position still updates.
  - Arrival: pos_x==Xe and pos_y==Ye after the update gives DONE next cycle, with done high the same edge.
  - Stall: the stall counter clears on any accepted event and increments otherwise; reaching STALL_CYC sets bit2, FAULT.
  - All fault bits detected in one cycle are ORed.
- DONE: any step event sets bit2 (overshoot), moves to FAULT, no position update.
- FAULT: position frozen; events ignored; only arm or reset leaves.
- IDLE: events ignored, no fault.
- Outputs are registered; busy, done and fault are one-hot with the state (all 0 in IDLE).
- Reset mid-operation returns everything to reset values on the next edge.
- Position/count wrap: not checked; overshoot catches it first for legal endpoints.

Decomposition:
- Shared package step_if_pkg holds:
  - state encoding IDLE/TRACK/DONE/FAULT;
  - fault_code bit indices FC_CONFLICT=0, FC_SEQ=1, FC_RANGE=2;
  - axis direction constants.
- One natural sub-module: step_edge_capture, instantiated once per axis. It registers a +/- pulse pair and outputs pos_evt, neg_evt and conflict.

Test Plan:
- arm with Xe=5, Ye=3; drive the interpolator-legal pulse sequence -> step_cnt=8, pos=(5,3), done=1, fault_code=0.
- arm Xe=-4, Ye=4; first cycle -X and +Y together (F=0), then alternating legal steps -> done with pos=(-4,4), step_cnt=8.
- arm Xe=3, Ye=2; assert r_Ax and r_fAx together -> fault=1, fault_code=3'b001, pos_x stays 0.
- arm Xe=3, Ye=1; send +X (F=1) then +X again -> fault_code bit1 set, pos_x=1.
- arm Xe=2, Ye=0; 2 +X pulses then 1 more -> done, then FAULT with fault_code=3'b100, pos_x=2.
- STALL_CYC=16: arm Xe=1, Ye=1, no pulses -> fault after 16 cycles with bit2 set; then hold r_Ax high 5 cycles after a re-arm -> exactly 1 step counted; reset mid-TRACK -> all outputs 0, IDLE.
